// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer bundle for fifo_sync_param
//
// Purpose: groups the FIFO data, handshake, status and error signals.
// Modports:
//   master : testbench or user logic; drives dataIn/write/read/clearErr,
//            observes dataOut, full, empty, almostFull, almostEmpty, count,
//            overflow, underflow.
//   slave  : the FIFO itself; the mirror image of master.
interface fifo_sync_param_if #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 8
);
   logic [WIDTH-1:0]    dataIn;
   logic                write;
   logic                read;
   logic                clearErr;
   logic [WIDTH-1:0]    dataOut;
   logic                full;
   logic                empty;
   logic                almostFull;
   logic                almostEmpty;
   logic [DEPTH_LOG2:0] count;
   logic                overflow;
   logic                underflow;

   modport master (
      output dataIn, write, read, clearErr,
      input  dataOut, full, empty, almostFull, almostEmpty, count,
             overflow, underflow
   );

   modport slave (
      input  dataIn, write, read, clearErr,
      output dataOut, full, empty, almostFull, almostEmpty, count,
             overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with FWFT option
//
// Purpose: synchronous FIFO of 2**DEPTH_LOG2 words of WIDTH bits with
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags. FWFT=0 gives a registered read (data one cycle
// after the read request); FWFT=1 presents the head word combinationally.
// Ports:
//   CLK : clock, all state changes on posedge
//   RST : asynchronous active-high reset
//   bus : fifo_sync_param_if.slave (data, handshake, status, error flags)
module fifo_sync_param #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 8,
   parameter int FWFT       = 0,
   parameter int AFULL_LVL  = 2**DEPTH_LOG2 - 4,
   parameter int AEMPTY_LVL = 4
) (
   input logic              CLK,
   input logic              RST,
   fifo_sync_param_if.slave bus
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] AFULL_C  = AFULL_LVL[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] AEMPTY_C = AEMPTY_LVL[DEPTH_LOG2:0];

   // Storage is intentionally not reset; the pointers define what is valid.
   logic [WIDTH-1:0]      mem_q [DEPTH];

   // One extra pointer bit separates the full and empty cases.
   logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [DEPTH_LOG2-1:0] rd_addr;
   logic [DEPTH_LOG2:0]   count_w;
   logic                  full_w;
   logic                  empty_w;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_addr = wr_ptr_q[DEPTH_LOG2-1:0];
   assign rd_addr = rd_ptr_q[DEPTH_LOG2-1:0];

   // Status comes only from registered pointers, so write/read never reach
   // full/empty/count combinationally.
   assign count_w = wr_ptr_q - rd_ptr_q;
   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (wr_addr == rd_addr) &&
                    (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

   always_comb begin
      wr_acc   = bus.write & ~full_w;
      rd_acc   = bus.read  & ~empty_w;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      // A new error in the same cycle as clearErr keeps the flag set.
      ovf_d = (bus.write & full_w)  | (ovf_q & ~bus.clearErr);
      udf_d = (bus.read  & empty_w) | (udf_q & ~bus.clearErr);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_acc) mem_q[wr_addr] <= bus.dataIn;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.dataOut = empty_w ? '0 : mem_q[rd_addr];
      end else begin : g_std
         logic [WIDTH-1:0] dout_q;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST)         dout_q <= '0;
            else if (rd_acc) dout_q <= mem_q[rd_addr];
         end
         assign bus.dataOut = dout_q;
      end
   endgenerate

   assign bus.full        = full_w;
   assign bus.empty       = empty_w;
   assign bus.count       = count_w;
   assign bus.almostFull  = (count_w >= AFULL_C);
   assign bus.almostEmpty = (count_w <= AEMPTY_C);
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - scoreboard bench for fifo_sync_param (std and FWFT)
module tb_fifo_sync_param;

   localparam int W     = 8;
   localparam int DL    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] din;
   logic       wr, rd, clr;

   always #5 CLK = ~CLK;

   fifo_sync_param_if #(.WIDTH(W), .DEPTH_LOG2(DL)) if0 ();
   fifo_sync_param_if #(.WIDTH(W), .DEPTH_LOG2(DL)) if1 ();

   assign if0.dataIn = din;  assign if1.dataIn = din;
   assign if0.write  = wr;   assign if1.write  = wr;
   assign if0.read   = rd;   assign if1.read   = rd;
   assign if0.clearErr = clr; assign if1.clearErr = clr;

   fifo_sync_param #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(0),
                     .AFULL_LVL(AF), .AEMPTY_LVL(AE))
      dut_std (.CLK(CLK), .RST(RST), .bus(if0));

   fifo_sync_param #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(1),
                     .AFULL_LVL(AF), .AEMPTY_LVL(AE))
      dut_fwft (.CLK(CLK), .RST(RST), .bus(if1));

   typedef struct {
      int         cnt;
      logic [7:0] d0;
      logic [7:0] d1;
      bit         ovf;
      bit         udf;
   } exp_t;

   int         mq[$];
   bit         m_ovf, m_udf;
   logic [7:0] m_d0;
   exp_t       exp_q[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic exp_t snap();
      exp_t e;
      int   t;
      e.cnt = mq.size();
      e.d0  = m_d0;
      e.ovf = m_ovf;
      e.udf = m_udf;
      if (mq.size() > 0) begin
         t    = mq[0];
         e.d1 = t[7:0];
      end else begin
         e.d1 = 8'h00;
      end
      return e;
   endfunction

   task automatic check_all(input exp_t e);
      chk("std.count",  32'(if0.count),     e.cnt);
      chk("std.full",   32'(if0.full),      32'(e.cnt == DEPTH));
      chk("std.empty",  32'(if0.empty),     32'(e.cnt == 0));
      chk("std.afull",  32'(if0.almostFull),  32'(e.cnt >= AF));
      chk("std.aempty", 32'(if0.almostEmpty), 32'(e.cnt <= AE));
      chk("std.ovf",    32'(if0.overflow),  32'(e.ovf));
      chk("std.udf",    32'(if0.underflow), 32'(e.udf));
      chk("std.dout",   32'(if0.dataOut),   32'(e.d0));
      chk("fwft.count", 32'(if1.count),     e.cnt);
      chk("fwft.full",  32'(if1.full),      32'(e.cnt == DEPTH));
      chk("fwft.empty", 32'(if1.empty),     32'(e.cnt == 0));
      chk("fwft.afull", 32'(if1.almostFull),  32'(e.cnt >= AF));
      chk("fwft.aempty",32'(if1.almostEmpty), 32'(e.cnt <= AE));
      chk("fwft.ovf",   32'(if1.overflow),  32'(e.ovf));
      chk("fwft.udf",   32'(if1.underflow), 32'(e.udf));
      chk("fwft.dout",  32'(if1.dataOut),   32'(e.d1));
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_d0  = 8'h00;
   endtask

   // One clock of stimulus; the reference model is updated at the edge and
   // the expected post-edge state is queued for the monitor.
   task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
      int n;
      int h;
      bit was_full, was_empty;
      wr = w; din = d; rd = r; clr = c;
      @(posedge CLK);
      n         = mq.size();
      was_full  = (n == DEPTH);
      was_empty = (n == 0);
      if (r && !was_empty) begin
         h    = mq.pop_front();
         m_d0 = h[7:0];
      end
      if (w && !was_full) mq.push_back(int'(d));
      m_ovf = (w && was_full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_udf);
      exp_q.push_back(snap());
      @(negedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_all(e);
      end
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      RST = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
      model_reset();
      #1;
      check_all(snap());
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;

      // Three writes then three reads.
      cycle(1, 8'h11, 0, 0);
      cycle(1, 8'h22, 0, 0);
      cycle(1, 8'h33, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);

      // Fill to capacity, overflow with 0xAA, then drain.
      for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
      cycle(1, 8'hAA, 0, 0);
      for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 0, 1);

      // Pointer wrap with a constant occupancy of 5.
      for (int i = 0; i < 5; i++) cycle(1, 8'(8'h60 + i), 0, 0);
      for (int i = 0; i < 40; i++) cycle(1, 8'(8'h80 + i), 1, 0);
      for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);

      // Underflow, clear, and clear coincident with a new underflow.
      cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 0, 1);
      cycle(0, 8'h00, 1, 1);
      cycle(0, 8'h00, 0, 1);

      // Fall-through visibility and simultaneous write/read while empty.
      cycle(1, 8'h5A, 0, 0);
      cycle(0, 8'h00, 0, 0);
      cycle(0, 8'h00, 1, 0);
      cycle(1, 8'h3C, 1, 0);
      cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 0, 1);

      // Random traffic: write-heavy phase then read-heavy phase.
      for (int i = 0; i < 400; i++) begin
         bit w, r, c;
         w = ($urandom_range(0, 99) < ((i < 200) ? 70 : 35));
         r = ($urandom_range(0, 99) < ((i < 200) ? 35 : 70));
         c = ($urandom_range(0, 99) < 5);
         cycle(w, 8'($urandom), r, c);
      end

      // Drain, provoke an error, fill to 7, then reset mid-cycle.
      while (mq.size() > 0) cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 1, 0);
      for (int i = 0; i < 7; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
      wr = 1'b1; din = 8'h99;
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      check_all(snap());
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0; wr = 1'b0;
      #1;
      check_all(snap());
      cycle(1, 8'h77, 0, 0);
      cycle(1, 8'h88, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);

      @(negedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO. It is the next generation of the 8-bit/256-entry byte FIFO used between the UART/SPI front-ends and the CPU bus.
- Generalises data width and depth and fixes wrap and full/empty ambiguity with an extra pointer bit.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode.
- Single clock domain; instantiated wherever a byte or word stream crosses between producer and consumer logic at CLK.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH_LOG2, 8, log2 of storage depth; capacity = 2**DEPTH_LOG2 entries (>=2).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_LVL, 2**DEPTH_LOG2-4, almostFull asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 4, almostEmpty asserts when count <= AEMPTY_LVL.

Ports:
- CLK  in  1  system clock, all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- dataIn  in  WIDTH  write data.
- write  in  1  write request.
- read  in  1  read request.
- clearErr  in  1  synchronous clear of overflow/underflow.
- dataOut  out  WIDTH  read data.
- full  out  1  count == 2**DEPTH_LOG2.
- empty  out  1  count == 0.
- almostFull  out  1  count >= AFULL_LVL.
- almostEmpty  out  1  count <= AEMPTY_LVL.
- count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset (RST=1, asynchronous, any time including mid-transfer):
  - Write/read pointers = 0; count = 0; dataOut = 0; overflow = underflow = 0.
  - full = 0, empty = 1, almostEmpty = 1, almostFull = (AFULL_LVL == 0).
  - Storage array is not reset. Contents are discarded logically.
- Pointers are DEPTH_LOG2+1 bits.
  - Address = low DEPTH_LOG2 bits; wrap-around is natural modulo 2**(DEPTH_LOG2+1).
  - empty when pointers equal; full when the low bits are equal and the MSBs differ.
  - count = wrPtr - rdPtr (modulo width); all flags are derived combinationally from registered pointers.
- Write acceptance: wrAcc = write & ~full.
  - On accept: mem[wrPtr] <= dataIn; wrPtr++.
  - Write while full: rejected, data dropped, overflow <= 1.
- Read acceptance: rdAcc = read & ~empty.
  - On accept: rdPtr++.
  - Read while empty: rejected, underflow <= 1, pointers unchanged.
- Simultaneous write and read:
  - Each is judged against the flags at the start of the cycle.
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected with overflow.
  - Empty: write accepted, read rejected with underflow.
- FWFT=0 (standard mode):
  - On rdAcc, dataOut <= mem[rdPtr] at that edge, so data is valid the cycle after the read request (1-cycle latency).
  - dataOut holds its value otherwise, including on rejected reads.
- FWFT=1:
  - dataOut = mem[rdPtr] combinationally whenever ~empty; dataOut = 0 when empty.
  - read acknowledges/pops the current head.
  - Write-to-visible latency is 1 cycle: data written at edge N is on dataOut after edge N if the FIFO was empty.
- Error flags:
  - Set on the offending edge; they stay set until clearErr=1 at a posedge or RST.
  - If clearErr and a new error occur in the same cycle, set wins.
- No combinational path from write/read to full/empty/count.

Test Plan:
- Reset then write 0x11,0x22,0x33 on consecutive cycles -> count=3, empty=0; FWFT=0: read 3 cycles -> dataOut 0x11,0x22,0x33 each one cycle after its read; empty=1 after the third read.
- DEPTH_LOG2=4: write 16 words 0..15 -> full=1 at count=16, almostFull set from count 12; a 17th write (0xAA) -> overflow=1, count stays 16; read all 16 -> 0..15 in order, 0xAA never appears.
- Wrap-around: DEPTH_LOG2=4, repeat 40 cycles of write+read together after pre-filling 5 words -> count constant 5, data order preserved across pointer wrap, full and empty stay 0.
- Read on empty FIFO -> underflow=1, dataOut unchanged, count 0; clearErr pulse -> underflow=0; clearErr coincident with another empty read -> underflow stays 1.
- FWFT=1: write 0x5A into empty FIFO -> dataOut=0x5A the next cycle with no read; read pulse -> empty=1, dataOut=0; simultaneous write+read while empty -> write accepted, underflow=1.
- Assert RST mid-stream with count=7 and write high -> count=0, empty=1, dataOut=0, flags cleared immediately without waiting for a clock edge; first write after release is read back first.
